elevator_scan_controller: RTL and testbench

Parametrised car-movement controller for an N-floor elevator. It generalises the fixed 3-floor controller in four ways:
- configurable floor count;
- per-floor latched requests;
- SCAN (collective) scheduling with a direction register;
- a single explicit state machine that owns the door and move timing, replacing separate clock-divider submodules.

It sits between the button/LED front end and the floor/door indicator drivers.

---
 rtl/elevator_scan_controller_if.sv | 28 ++
 rtl/elevator_scan_controller.sv | 138 +++++++++++++
 tb/tb_elevator_scan_controller.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_scan_controller_if.sv
// Elevator controller front-end bundle: call/safety inputs and car status.
// master drives calls/safety and reads status; slave is the controller.
interface elevator_scan_controller_if #(
   parameter int NUM_FLOORS = 3,
   parameter int FLOOR_W    = 2
);
   logic [NUM_FLOORS-1:0] call_req;
   logic                  sos_mode;
   logic                  weight_limit_exceeded;
   logic [NUM_FLOORS-1:0] pending;
   logic [NUM_FLOORS-1:0] floor_onehot;
   logic [FLOOR_W-1:0]    floor_idx;
   logic                  door;
   logic                  moving;
   logic                  dir_up;

   modport master (
      output call_req, sos_mode, weight_limit_exceeded,
      input  pending, floor_onehot, floor_idx,
      input  door, moving, dir_up
   );

   modport slave (
      input  call_req, sos_mode, weight_limit_exceeded,
      output pending, floor_onehot, floor_idx,
      output door, moving, dir_up
   );
endinterface

// File: rtl/elevator_scan_controller.sv
// N-floor SCAN elevator controller: latched calls, direction register, door/move timing.
// Ports: clk, reset (sync, active-high), bus (slave: calls/safety in, car status out).
module elevator_scan_controller #(
   parameter int NUM_FLOORS = 3,
   parameter int FLOOR_W    = 2,
   parameter int DOOR_TICKS = 2,
   parameter int MOVE_TICKS = 5
) (
   input  logic clk,
   input  logic reset,
   elevator_scan_controller_if.slave bus
);
   localparam int TMAX = (DOOR_TICKS > MOVE_TICKS) ? DOOR_TICKS : MOVE_TICKS;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0]      DOOR_LAST = TW'(DOOR_TICKS - 1);
   localparam logic [TW-1:0]      MOVE_LAST = TW'(MOVE_TICKS - 1);
   localparam logic [FLOOR_W-1:0] TOP       = FLOOR_W'(NUM_FLOORS - 1);
   localparam logic [NUM_FLOORS-1:0] ONE    = NUM_FLOORS'(1);

   typedef enum logic [1:0] {IDLE, DEPART, MOVING, DWELL} state_t;

   state_t                state_q;
   logic [TW-1:0]         timer_q;
   logic [FLOOR_W-1:0]    floor_q;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic                  door_q, moving_q, dir_up_q;

   logic [NUM_FLOORS-1:0] here_oh, next_oh, above, below;
   logic [NUM_FLOORS-1:0] set_mask, clr_mask;
   logic [FLOOR_W-1:0]    next_floor;
   logic ahead_up, ahead_dn, open_here, here_call, arrive;

   always_comb begin
      here_oh  = ONE << floor_q;
      // Floors strictly below are the bits under the one-hot position.
      below    = here_oh - ONE;
      above    = ~(below | here_oh);
      ahead_up = |(pending_q & above);
      ahead_dn = |(pending_q & below);

      open_here = (state_q == IDLE) || (state_q == DWELL);
      here_call = |(bus.call_req & here_oh);
      // A call at the floor the door is open on is served by the open door.
      set_mask  = open_here ? (bus.call_req & ~here_oh) : bus.call_req;

      next_floor = floor_q;
      if (dir_up_q) begin
         if (floor_q != TOP) next_floor = floor_q + FLOOR_W'(1);
      end else begin
         if (floor_q != '0) next_floor = floor_q - FLOOR_W'(1);
      end
      next_oh = ONE << next_floor;

      arrive = (state_q == MOVING) && !bus.sos_mode &&
               (timer_q == MOVE_LAST) && |(pending_q & next_oh);

      clr_mask  = arrive ? next_oh : '0;
      // Clear wins over a same-cycle set of the same floor.
      pending_d = (pending_q | set_mask) & ~clr_mask;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         floor_q   <= '0;
         pending_q <= '0;
         door_q    <= 1'b1;
         moving_q  <= 1'b0;
         dir_up_q  <= 1'b1;
      end else begin
         pending_q <= pending_d;
         unique case (state_q)
            IDLE: begin
               if (|pending_q && !bus.sos_mode) begin
                  // Keep heading up only if there is work above and
                  // either already going up or nothing below.
                  dir_up_q <= ahead_up && (dir_up_q || !ahead_dn);
                  state_q  <= DEPART;
                  timer_q  <= '0;
               end
            end
            DEPART: begin
               if (bus.weight_limit_exceeded || bus.sos_mode) begin
                  timer_q <= '0;
               end else if (timer_q == DOOR_LAST) begin
                  state_q  <= MOVING;
                  timer_q  <= '0;
                  door_q   <= 1'b0;
                  moving_q <= 1'b1;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            MOVING: begin
               if (!bus.sos_mode) begin
                  if (timer_q == MOVE_LAST) begin
                     floor_q <= next_floor;
                     timer_q <= '0;
                     if (arrive) begin
                        state_q  <= DWELL;
                        door_q   <= 1'b1;
                        moving_q <= 1'b0;
                     end
                  end else begin
                     timer_q <= timer_q + TW'(1);
                  end
               end
            end
            DWELL: begin
               if (bus.weight_limit_exceeded || bus.sos_mode || here_call) begin
                  timer_q <= '0;
               end else if (timer_q == DOOR_LAST) begin
                  timer_q <= '0;
                  if (dir_up_q ? ahead_up : ahead_dn) begin
                     state_q <= DEPART;
                  end else if (dir_up_q ? ahead_dn : ahead_up) begin
                     dir_up_q <= ~dir_up_q;
                     state_q  <= DEPART;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.pending      = pending_q;
   assign bus.floor_onehot = here_oh;
   assign bus.floor_idx    = floor_q;
   assign bus.door         = door_q;
   assign bus.moving       = moving_q;
   assign bus.dir_up       = dir_up_q;
endmodule

// File: tb/tb_elevator_scan_controller.sv
// Directed bench: 3-floor table run plus 5-floor multi-cycle sequences.
// Inputs change on negedge; outputs are checked on the following negedge.
module tb_elevator_scan_controller;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   elevator_scan_controller_if #(.NUM_FLOORS(3), .FLOOR_W(2)) if3 ();
   elevator_scan_controller_if #(.NUM_FLOORS(5), .FLOOR_W(3)) if5 ();

   elevator_scan_controller u3 (
      .clk   (clk),
      .reset (reset),
      .bus   (if3)
   );

   elevator_scan_controller #(
      .NUM_FLOORS (5),
      .FLOOR_W    (3),
      .DOOR_TICKS (2),
      .MOVE_TICKS (5)
   ) u5 (
      .clk   (clk),
      .reset (reset),
      .bus   (if5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] call;
      logic [2:0] pend;
      int         flr;
      logic       door;
      logic       mov;
      logic       dir;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic add(input logic [2:0] c, input logic [2:0] p,
                      input int f, input logic d, input logic m,
                      input logic u);
      vec_t v;
      v.call = c; v.pend = p; v.flr = f;
      v.door = d; v.mov = m; v.dir = u;
      tbl.push_back(v);
   endtask

   task automatic pulse5(input logic [4:0] c);
      if5.call_req = c;
      step();
      if5.call_req = '0;
   endtask

   task automatic wait_floor5(input int tgt, output int n);
      n = 0;
      while (int'(if5.floor_idx) != tgt && n < 80) begin
         step();
         n++;
      end
      chk($sformatf("reach_floor_%0d", tgt), int'(if5.floor_idx), tgt);
   endtask

   task automatic wait_moving5(output int n);
      n = 0;
      while (!if5.moving && n < 80) begin
         step();
         n++;
      end
      chk("moving_rise", int'(if5.moving), 1);
   endtask

   task automatic chk5(input string nm, input int p, input int f,
                       input logic d, input logic m, input logic u);
      chk({nm, "_pending"}, int'(if5.pending), p);
      chk({nm, "_floor"}, int'(if5.floor_idx), f);
      chk({nm, "_onehot"}, int'(if5.floor_onehot), 1 << f);
      chk({nm, "_door_mov_dir"},
          int'({if5.door, if5.moving, if5.dir_up}), int'({d, m, u}));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int m;
      logic [2:0] one;
      logic       hold_ok;
      checks = 0;
      errors = 0;
      reset = 1'b1;
      if3.call_req = '0;
      if3.sos_mode = 1'b0;
      if3.weight_limit_exceeded = 1'b0;
      if5.call_req = '0;
      if5.sos_mode = 1'b0;
      if5.weight_limit_exceeded = 1'b0;

      // Row k shows the outputs one edge after its call is applied.
      add(3'b000, 3'b000, 0, 1, 0, 1);
      add(3'b100, 3'b100, 0, 1, 0, 1);
      add(3'b000, 3'b100, 0, 1, 0, 1);
      add(3'b000, 3'b100, 0, 1, 0, 1);
      repeat (5) add(3'b000, 3'b100, 0, 0, 1, 1);
      repeat (5) add(3'b000, 3'b100, 1, 0, 1, 1);
      repeat (3) add(3'b000, 3'b000, 2, 1, 0, 1);
      add(3'b100, 3'b000, 2, 1, 0, 1);
      add(3'b001, 3'b001, 2, 1, 0, 1);
      add(3'b000, 3'b001, 2, 1, 0, 0);

      step();
      step();
      chk("reset3", int'({if3.pending, if3.floor_onehot, if3.floor_idx,
                          if3.door, if3.moving, if3.dir_up}),
          int'({3'b000, 3'b001, 2'd0, 3'b101}));
      chk5("reset5", 0, 0, 1, 0, 1);
      reset = 1'b0;

      // Call floor 2 from floor 0 on the 3-floor car, then call down.
      foreach (tbl[k]) begin
         if3.call_req = tbl[k].call;
         step();
         one = 3'b001 << tbl[k].flr;
         chk($sformatf("row%0d", k),
             int'({if3.pending, if3.floor_onehot, if3.floor_idx,
                   if3.door, if3.moving, if3.dir_up}),
             int'({tbl[k].pend, one, 2'(tbl[k].flr),
                   tbl[k].door, tbl[k].mov, tbl[k].dir}));
      end
      if3.call_req = '0;

      // Intermediate stop on the way up, then reversal.
      pulse5(5'b10000);
      chk("call4_latched", int'(if5.pending), 5'b10000);
      wait_floor5(2, n);
      step();
      step();
      pulse5(5'b01000);
      chk("call3_midtravel", int'(if5.pending), 5'b11000);
      wait_floor5(3, n);
      chk5("stop3", 5'b10000, 3, 1, 0, 1);
      wait_floor5(4, n);
      chk5("stop4", 0, 4, 1, 0, 1);
      pulse5(5'b00001);
      step();
      chk5("reverse", 5'b00001, 4, 1, 0, 0);

      // SOS freeze: nominal 7 edges to floor 3, plus 7 held edges.
      step();
      step();
      chk("depart_down_moving", int'(if5.moving), 1);
      if5.sos_mode = 1'b1;
      repeat (7) step();
      chk5("sos_frozen", 5'b00001, 4, 0, 1, 0);
      if5.sos_mode = 1'b0;
      wait_floor5(3, m);
      chk("sos_arrival_delay", 2 + 7 + m, 14);

      // Call at the current floor while moving needs a return trip.
      pulse5(5'b01000);
      chk("call_here_moving", int'(if5.pending), 5'b01001);
      wait_floor5(0, n);
      chk5("stop0", 5'b01000, 0, 1, 0, 0);
      wait_floor5(3, n);
      chk5("return_trip", 0, 3, 1, 0, 1);

      // Calling the open floor restarts the dwell and is not latched.
      if5.call_req = 5'b01010;
      step();
      if5.call_req = 5'b01000;
      step();
      step();
      if5.call_req = '0;
      chk("dwell_call_not_latched", int'(if5.pending), 5'b00010);
      wait_moving5(n);
      chk("dwell_restart_delay", n, 4);
      chk("dwell_reverse_dir", int'(if5.dir_up), 0);

      // Overload holds the door in departure.
      wait_floor5(1, n);
      step();
      step();
      if5.weight_limit_exceeded = 1'b1;
      pulse5(5'b00001);
      hold_ok = !if5.moving && if5.door;
      repeat (9) begin
         step();
         hold_ok = hold_ok && !if5.moving && if5.door;
      end
      chk("overload_hold", int'(hold_ok), 1);
      chk("overload_pending", int'(if5.pending), 5'b00001);
      if5.weight_limit_exceeded = 1'b0;
      // First free edge counts 0->1, the next is the final door count.
      wait_moving5(n);
      chk("overload_release_delay", n, 2);

      // Reset in the middle of a move.
      wait_floor5(0, n);
      pulse5(5'b10000);
      wait_floor5(3, n);
      step();
      step();
      chk("pre_reset_moving", int'(if5.moving), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk5("mid_move_reset", 0, 0, 1, 0, 1);
      step();
      chk5("post_reset_idle", 0, 0, 1, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
